mat_seq_ctrl: RTL and testbench
===============================

MAT_SEQ_CTRL -- requirements
Module: mat_seq_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 in_valid  in  1  high while a matrix-set element stream is presented.
REQ-004 matrix_size  in  2  size code (0:2x2, 1:4x4, 2:8x8, 3:16x16); valid on first in_valid cycle only.
REQ-005 in_valid2  in  1  high for exactly 3 cycles per command.
REQ-006 matrix_idx  in  5  matrix index; one per in_valid2 cycle (A, B, C order).
REQ-007 mode  in  2  operation mode; valid on first in_valid2 cycle only.
REQ-008 dp_done  in  1  single-cycle completion pulse from datapath.
REQ-009 dp_result  in  50  signed datapath result; valid when dp_done=1.
REQ-010 mem_we  out  1  element write strobe to matrix SRAM.
REQ-011 mem_waddr  out  13  write address = {matrix number[4:0], element number[7:0]}.
REQ-012 cmd_valid  out  1  one-cycle start pulse to datapath.
REQ-013 cmd_idx_a, cmd_idx_b, cmd_idx_c  out  5 each  captured indices; stable from cmd_valid until dp_done.
REQ-014 cmd_mode  out  2  captured mode; cmd_size  out  2  latched size code.
REQ-015 out_valid  out  1  one-cycle result strobe; out_value  out  50  signed result.
REQ-016 load_err  out  1  one-cycle pulse on aborted load.

Function
REQ-017 States: IDLE, LOAD, WAIT_CMD, CAPT, ISSUE, WAIT_DP, OUT.
REQ-018 IDLE: in_valid=1 -> latch matrix_size into cmd_size, write element 0 of matrix 0, go LOAD.
REQ-019 LOAD: each in_valid cycle asserts mem_we combinationally, same cycle; element counter wraps at N*N-1 (N=2,4,8,16), matrix counter then increments.
REQ-020 Load complete after element N*N-1 of matrix 31 (32*N*N writes total) -> WAIT_CMD; round counter cleared.
REQ-021 in_valid low in LOAD before completion -> load_err pulse next cycle, state IDLE, counters cleared.
REQ-022 WAIT_CMD: in_valid2=1 -> capture matrix_idx into cmd_idx_a and mode into cmd_mode, go CAPT; next two cycles capture cmd_idx_b then cmd_idx_c.
REQ-023 in_valid2 low during CAPT -> command discarded, return WAIT_CMD, no cmd_valid.
REQ-024 ISSUE: cmd_valid=1 on the cycle after cmd_idx_c captured, for exactly one cycle; then WAIT_DP.
REQ-025 WAIT_DP: dp_done=1 -> register dp_result, go OUT; no timeout.
REQ-026 OUT: out_valid=1 and out_value=registered result for exactly one cycle (one cycle after dp_done); round counter increments.
REQ-027 out_value SHALL be 0 whenever out_valid=0.
REQ-028 After 10th OUT -> IDLE (new load required); otherwise -> WAIT_CMD.
REQ-029 in_valid outside IDLE/LOAD and in_valid2 outside WAIT_CMD/CAPT SHALL be ignored.
REQ-030 dp_done outside WAIT_DP SHALL be ignored.
REQ-031 mem_we=0 in every state except qualified LOAD/IDLE-entry cycles.

Reset
REQ-032 rst=1 at any edge, including mid-load or mid-command: state IDLE; all counters 0; mem_we, cmd_valid, out_valid, load_err 0; out_value, mem_waddr, cmd_* all 0.
REQ-033 rst has priority over every input in the same cycle.

Structure
REQ-034 Shared package mat_pkg: state enum, size-code constants, MAT_CNT=32, ROUNDS=10, ADDR_W=13, RES_W=50.
REQ-035 One sub-module mat_addr_gen (element/matrix counters, wrap by size code, last-element flag); FSM stays in top.

Verification
REQ-036 size=0, 128 in_valid cycles -> 128 mem_we, last mem_waddr=0x1F03, state WAIT_CMD.
REQ-037 size=3, 8192 cycles -> addresses 0x0000..0x1FFF contiguous, no gaps, then WAIT_CMD.
REQ-038 in_valid2 idx 3,7,31 mode 2; dp_done with result -5 after 20 cycles -> cmd_valid 1 cycle after idx 31, out_valid 1 cycle after dp_done, out_value=-5, then 0.
REQ-039 10 commands after load -> 10 single-cycle out_valid pulses, then IDLE; 11th in_valid2 ignored.
REQ-040 in_valid dropped after 50 elements (size=1) -> load_err pulse, IDLE; next full load succeeds from address 0.
REQ-041 rst asserted in WAIT_DP then dp_done pulses -> no out_valid, all outputs 0.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared constants for the matrix sequencing controller: widths, FSM state codes,
// size codes and the per-size element wrap point.
package mat_pkg;

   localparam int MAT_CNT = 32;
   localparam int ROUNDS  = 10;
   localparam int ADDR_W  = 13;
   localparam int RES_W   = 50;
   localparam int IDX_W   = 5;
   localparam int ELEM_W  = 8;
   localparam int RND_W   = 4;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD     = 3'd1;
   localparam logic [2:0] ST_WAIT_CMD = 3'd2;
   localparam logic [2:0] ST_CAPT     = 3'd3;
   localparam logic [2:0] ST_ISSUE    = 3'd4;
   localparam logic [2:0] ST_WAIT_DP  = 3'd5;
   localparam logic [2:0] ST_OUT      = 3'd6;

   localparam logic [1:0] SZ_2X2   = 2'd0;
   localparam logic [1:0] SZ_4X4   = 2'd1;
   localparam logic [1:0] SZ_8X8   = 2'd2;
   localparam logic [1:0] SZ_16X16 = 2'd3;

   // Index of the last element of one N x N matrix for a given size code.
   function automatic logic [ELEM_W-1:0] last_elem(input logic [1:0] size);
      logic [ELEM_W-1:0] lim;
      case (size)
         SZ_2X2:  lim = 8'd3;
         SZ_4X4:  lim = 8'd15;
         SZ_8X8:  lim = 8'd63;
         default: lim = 8'd255;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/mat_addr_gen.sv
// Element/matrix write counters for the matrix-set load; the element counter wraps
// at the size-dependent end of a matrix and the flag marks the very last write.
module mat_addr_gen
   import mat_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              adv,
   input  logic [1:0]        size,
   output logic [ELEM_W-1:0] elem,
   output logic [IDX_W-1:0]  mat,
   output logic              last_flag
);

   logic [ELEM_W-1:0] elem_q;
   logic [IDX_W-1:0]  mat_q;
   logic              elem_last;

   assign elem_last = (elem_q == last_elem(size));
   assign last_flag = elem_last && (mat_q == IDX_W'(MAT_CNT - 1));
   assign elem      = elem_q;
   assign mat       = mat_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         elem_q <= '0;
         mat_q  <= '0;
      end else if (adv) begin
         if (elem_last) begin
            elem_q <= '0;
            mat_q  <= mat_q + IDX_W'(1);
         end else begin
            elem_q <= elem_q + ELEM_W'(1);
         end
      end
   end

endmodule

// File: rtl/mat_seq_ctrl.sv
// Matrix sequencing controller: loads 32 matrices into SRAM, captures A/B/C commands,
// hands them to the datapath and returns ten results per loaded matrix set.
module mat_seq_ctrl
   import mat_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [1:0]              matrix_size,
   input  logic                    in_valid2,
   input  logic [4:0]              matrix_idx,
   input  logic [1:0]              mode,
   input  logic                    dp_done,
   input  logic signed [RES_W-1:0] dp_result,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_waddr,
   output logic                    cmd_valid,
   output logic [4:0]              cmd_idx_a,
   output logic [4:0]              cmd_idx_b,
   output logic [4:0]              cmd_idx_c,
   output logic [1:0]              cmd_mode,
   output logic [1:0]              cmd_size,
   output logic                    out_valid,
   output logic signed [RES_W-1:0] out_value,
   output logic                    load_err
);

   logic [2:0]              state_q;
   logic [2:0]              state_d;
   logic                    capt_q;
   logic [RND_W-1:0]        round_q;
   logic                    load_err_q;
   logic signed [RES_W-1:0] res_p0;

   logic                    wr_en;
   logic                    ag_clr;
   logic [1:0]              ag_size;
   logic [ELEM_W-1:0]       elem;
   logic [IDX_W-1:0]        mat;
   logic                    load_last;
   logic                    last_round;

   // The first element is written from IDLE, before cmd_size holds the new code.
   assign ag_size    = (state_q == ST_IDLE) ? matrix_size : cmd_size;
   assign wr_en      = !rst && in_valid && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
   assign ag_clr     = (state_q == ST_LOAD) && (!in_valid || load_last);
   assign last_round = (round_q == RND_W'(ROUNDS - 1));

   mat_addr_gen u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .clr       (ag_clr),
      .adv       (wr_en),
      .size      (ag_size),
      .elem      (elem),
      .mat       (mat),
      .last_flag (load_last)
   );

   assign mem_we    = wr_en;
   assign mem_waddr = wr_en ? {mat, elem} : '0;
   assign cmd_valid = (state_q == ST_ISSUE);
   assign out_valid = (state_q == ST_OUT);
   assign out_value = out_valid ? res_p0 : '0;
   assign load_err  = load_err_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (!in_valid)     state_d = ST_IDLE;
            else if (load_last) state_d = ST_WAIT_CMD;
         end
         ST_WAIT_CMD: begin
            if (in_valid2) state_d = ST_CAPT;
         end
         ST_CAPT: begin
            if (!in_valid2)  state_d = ST_WAIT_CMD;
            else if (capt_q) state_d = ST_ISSUE;
         end
         ST_ISSUE: state_d = ST_WAIT_DP;
         ST_WAIT_DP: begin
            if (dp_done) state_d = ST_OUT;
         end
         ST_OUT: state_d = last_round ? ST_IDLE : ST_WAIT_CMD;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         capt_q     <= 1'b0;
         round_q    <= '0;
         load_err_q <= 1'b0;
         cmd_idx_a  <= '0;
         cmd_idx_b  <= '0;
         cmd_idx_c  <= '0;
         cmd_mode   <= '0;
         cmd_size   <= '0;
         res_p0     <= '0;
      end else begin
         state_q    <= state_d;
         load_err_q <= (state_q == ST_LOAD) && !in_valid;
         case (state_q)
            ST_IDLE: begin
               if (in_valid) cmd_size <= matrix_size;
            end
            ST_LOAD: begin
               if (in_valid && load_last) round_q <= '0;
            end
            ST_WAIT_CMD: begin
               if (in_valid2) begin
                  cmd_idx_a <= matrix_idx;
                  cmd_mode  <= mode;
                  capt_q    <= 1'b0;
               end
            end
            ST_CAPT: begin
               if (in_valid2) begin
                  if (!capt_q) cmd_idx_b <= matrix_idx;
                  else         cmd_idx_c <= matrix_idx;
                  capt_q <= 1'b1;
               end
            end
            // Result register feeding the OUT cycle
            ST_WAIT_DP: begin
               if (dp_done) res_p0 <= dp_result;
            end
            ST_OUT: begin
               round_q <= last_round ? '0 : round_q + RND_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_seq_ctrl.sv
// Directed self-checking bench for mat_seq_ctrl: loads, commands, rounds, aborts, resets.
module tb_mat_seq_ctrl;
   import mat_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [1:0]        matrix_size;
   logic              in_valid2;
   logic [4:0]        matrix_idx;
   logic [1:0]        mode;
   logic              dp_done;
   logic signed [49:0] dp_result;
   logic              mem_we;
   logic [12:0]       mem_waddr;
   logic              cmd_valid;
   logic [4:0]        cmd_idx_a, cmd_idx_b, cmd_idx_c;
   logic [1:0]        cmd_mode, cmd_size;
   logic              out_valid;
   logic signed [49:0] out_value;
   logic              load_err;

   int n_checks = 0;
   int n_pass   = 0;

   int we_cnt, addr_bad;
   logic [12:0] first_a, last_a;
   int cv_cnt, ov_cnt, zero_bad;
   logic signed [49:0] seen_val;
   logic [4:0] seen_a, seen_b, seen_c;

   always #5 clk = ~clk;

   mat_seq_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .matrix_size(matrix_size),
      .in_valid2(in_valid2), .matrix_idx(matrix_idx), .mode(mode),
      .dp_done(dp_done), .dp_result(dp_result), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .cmd_valid(cmd_valid), .cmd_idx_a(cmd_idx_a), .cmd_idx_b(cmd_idx_b), .cmd_idx_c(cmd_idx_c),
      .cmd_mode(cmd_mode), .cmd_size(cmd_size), .out_valid(out_valid), .out_value(out_value),
      .load_err(load_err)
   );

   task automatic idle_inputs();
      in_valid = 0; matrix_size = 0; in_valid2 = 0; matrix_idx = 0;
      mode = 0; dp_done = 0; dp_result = 0;
   endtask

   // Drives n in_valid cycles; size is only meaningful on the first one, so it is scrambled afterwards.
   task automatic do_load(input logic [1:0] size, input int n);
      int per;
      logic [12:0] exp_a;
      per = (size == 2'd0) ? 4 : (size == 2'd1) ? 16 : (size == 2'd2) ? 64 : 256;
      we_cnt = 0; addr_bad = 0; first_a = '1; last_a = '1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk); in_valid = 1; matrix_size = (i == 0) ? size : ~size; #2;
         if (mem_we === 1'b1) begin
            we_cnt++;
            exp_a = {5'(i / per), 8'(i % per)};
            if (mem_waddr !== exp_a) addr_bad++;
            if (i == 0) first_a = mem_waddr;
            last_a = mem_waddr;
         end
      end
      @(negedge clk); in_valid = 0; matrix_size = 0;
   endtask

   task automatic sample_outs();
      if (cmd_valid === 1'b1) begin
         cv_cnt++; seen_a = cmd_idx_a; seen_b = cmd_idx_b; seen_c = cmd_idx_c;
      end
      if (out_valid === 1'b1) begin
         ov_cnt++; seen_val = out_value;
      end else if (out_value !== 50'sd0) zero_bad++;
   endtask

   task automatic run_cmd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                          input logic [1:0] md, input logic signed [49:0] res, input int dly);
      cv_cnt = 0; ov_cnt = 0; zero_bad = 0; seen_val = '0;
      seen_a = '0; seen_b = '0; seen_c = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); in_valid2 = 1;
         matrix_idx = (k == 0) ? a : (k == 1) ? b : c;
         mode = (k == 0) ? md : ~md; #2; sample_outs();
      end
      @(negedge clk); in_valid2 = 0; matrix_idx = 0; mode = 0; #2; sample_outs();
      for (int d = 0; d < dly; d++) begin
         @(negedge clk); #2; sample_outs();
      end
      @(negedge clk); dp_done = 1; dp_result = res; #2; sample_outs();
      @(negedge clk); dp_done = 0; dp_result = 0; #2; sample_outs();
      @(negedge clk); #2; sample_outs();
   endtask

   task automatic test_reset();
      idle_inputs(); rst = 1; in_valid = 1; matrix_size = 2'd3;
      repeat (2) @(negedge clk);
      #2;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_prio_mem_we: got %b want 0", mem_we); else n_pass++;
      @(negedge clk); rst = 0; in_valid = 0; matrix_size = 0; #2;
      n_checks++; if (dut.state_q !== ST_IDLE) $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
      n_checks++;
      if ({mem_we, cmd_valid, out_valid, load_err} !== 4'b0 || out_value !== 50'sd0 || mem_waddr !== 13'd0 ||
          {cmd_idx_a, cmd_idx_b, cmd_idx_c, cmd_mode, cmd_size} !== 19'd0)
         $display("FAIL rst_outputs: we=%b cv=%b ov=%b le=%b val=%0d addr=%h a=%0d b=%0d c=%0d m=%0d s=%0d want all 0",
                  mem_we, cmd_valid, out_valid, load_err, out_value, mem_waddr, cmd_idx_a, cmd_idx_b, cmd_idx_c, cmd_mode, cmd_size);
      else n_pass++;
   endtask

   task automatic test_load_size0();
      do_load(2'd0, 128); #2;
      n_checks++; if (we_cnt !== 128) $display("FAIL load0_we_count: got %0d want 128", we_cnt); else n_pass++;
      n_checks++; if (addr_bad !== 0) $display("FAIL load0_addr_seq: got %0d bad want 0", addr_bad); else n_pass++;
      n_checks++; if (last_a !== 13'h1F03) $display("FAIL load0_last_addr: got %h want 1f03", last_a); else n_pass++;
      n_checks++; if (dut.state_q !== ST_WAIT_CMD) $display("FAIL load0_state: got %0d want %0d", dut.state_q, ST_WAIT_CMD); else n_pass++;
      n_checks++; if (cmd_size !== 2'd0) $display("FAIL load0_cmd_size: got %0d want 0", cmd_size); else n_pass++;
      @(negedge clk); in_valid = 1; #2;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL load0_we_ignored: got %b want 0", mem_we); else n_pass++;
      @(negedge clk); in_valid = 0; #2;
      n_checks++; if (dut.state_q !== ST_WAIT_CMD) $display("FAIL load0_in_valid_ignored: got %0d want %0d", dut.state_q, ST_WAIT_CMD); else n_pass++;
   endtask

   task automatic test_command();
      int bad;
      @(negedge clk); in_valid2 = 1; matrix_idx = 5'd3; mode = 2'd2; #2;
      @(negedge clk); matrix_idx = 5'd7; mode = 2'd0; #2;
      @(negedge clk); matrix_idx = 5'd31; mode = 2'd1; #2;
      n_checks++; if (cmd_valid !== 1'b0 || cmd_idx_a !== 5'd3) $display("FAIL cmd_during_capt: cv=%b a=%0d want cv=0 a=3", cmd_valid, cmd_idx_a); else n_pass++;
      @(negedge clk); in_valid2 = 0; matrix_idx = 0; mode = 0; #2;
      n_checks++; if (cmd_valid !== 1'b1) $display("FAIL cmd_valid_issue: got %b want 1", cmd_valid); else n_pass++;
      n_checks++;
      if (cmd_idx_a !== 5'd3 || cmd_idx_b !== 5'd7 || cmd_idx_c !== 5'd31 || cmd_mode !== 2'd2)
         $display("FAIL cmd_capture: got a=%0d b=%0d c=%0d m=%0d want 3 7 31 2", cmd_idx_a, cmd_idx_b, cmd_idx_c, cmd_mode);
      else n_pass++;
      @(negedge clk); #2;
      n_checks++; if (cmd_valid !== 1'b0) $display("FAIL cmd_valid_one_cycle: got %b want 0", cmd_valid); else n_pass++;
      bad = 0;
      for (int d = 0; d < 18; d++) begin
         @(negedge clk); in_valid = (d == 5); in_valid2 = (d == 7); matrix_idx = 5'd1; #2;
         if (out_valid !== 1'b0 || cmd_valid !== 1'b0 || mem_we !== 1'b0 || cmd_idx_c !== 5'd31) bad++;
      end
      @(negedge clk); in_valid = 0; in_valid2 = 0; matrix_idx = 0; dp_done = 1; dp_result = -50'sd5; #2;
      n_checks++; if (bad !== 0) $display("FAIL wait_dp_quiet: got %0d bad cycles want 0", bad); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL out_on_dp_done_cycle: got %b want 0", out_valid); else n_pass++;
      @(negedge clk); dp_done = 0; dp_result = 0; #2;
      n_checks++; if (out_valid !== 1'b1 || out_value !== -50'sd5) $display("FAIL out_result: ov=%b val=%0d want 1 -5", out_valid, out_value); else n_pass++;
      @(negedge clk); #2;
      n_checks++; if (out_valid !== 1'b0 || out_value !== 50'sd0) $display("FAIL out_after: ov=%b val=%0d want 0 0", out_valid, out_value); else n_pass++;
      n_checks++; if (dut.state_q !== ST_WAIT_CMD) $display("FAIL cmd_return_state: got %0d want %0d", dut.state_q, ST_WAIT_CMD); else n_pass++;
   endtask

   task automatic test_discard();
      @(negedge clk); in_valid2 = 1; matrix_idx = 5'd9; mode = 2'd3; #2;
      @(negedge clk); in_valid2 = 0; #2;
      @(negedge clk); dp_done = 1; dp_result = 50'sd77; #2;
      n_checks++; if (dut.state_q !== ST_WAIT_CMD) $display("FAIL discard_state: got %0d want %0d", dut.state_q, ST_WAIT_CMD); else n_pass++;
      cv_cnt = 0; ov_cnt = 0; zero_bad = 0;
      @(negedge clk); dp_done = 0; dp_result = 0; in_valid2 = 1; #2; sample_outs();
      @(negedge clk); #2; sample_outs();
      @(negedge clk); in_valid2 = 0; #2; sample_outs();
      repeat (3) begin @(negedge clk); #2; sample_outs(); end
      n_checks++; if (cv_cnt !== 0 || ov_cnt !== 0) $display("FAIL discard_no_cmd: cv=%0d ov=%0d want 0 0", cv_cnt, ov_cnt); else n_pass++;
      n_checks++; if (dut.state_q !== ST_WAIT_CMD) $display("FAIL discard2_state: got %0d want %0d", dut.state_q, ST_WAIT_CMD); else n_pass++;
   endtask

   task automatic test_rounds();
      logic signed [49:0] r;
      logic [2:0] exp_st;
      for (int k = 2; k <= 10; k++) begin
         r = 50'sd1000 * k - 50'sd7;
         if (k[0]) r = -r;
         run_cmd(5'(k), 5'(k + 10), 5'(31 - k), 2'(k), r, 3 + k);
         exp_st = (k == 10) ? ST_IDLE : ST_WAIT_CMD;
         n_checks++;
         if (cv_cnt !== 1 || ov_cnt !== 1 || zero_bad !== 0 || seen_val !== r)
            $display("FAIL round_%0d: cv=%0d ov=%0d zbad=%0d val=%0d want 1 1 0 %0d", k, cv_cnt, ov_cnt, zero_bad, seen_val, r);
         else n_pass++;
         n_checks++;
         if (seen_a !== 5'(k) || seen_b !== 5'(k + 10) || seen_c !== 5'(31 - k) || dut.state_q !== exp_st)
            $display("FAIL round_%0d_idx: a=%0d b=%0d c=%0d st=%0d want %0d %0d %0d %0d", k, seen_a, seen_b, seen_c, dut.state_q, k, k + 10, 31 - k, exp_st);
         else n_pass++;
      end
      run_cmd(5'd1, 5'd2, 5'd3, 2'd1, 50'sd55, 2);
      n_checks++; if (cv_cnt !== 0 || ov_cnt !== 0) $display("FAIL round_11_ignored: cv=%0d ov=%0d want 0 0", cv_cnt, ov_cnt); else n_pass++;
      n_checks++; if (dut.state_q !== ST_IDLE) $display("FAIL round_11_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
   endtask

   task automatic test_load_err();
      do_load(2'd1, 50); #2;
      n_checks++; if (we_cnt !== 50 || addr_bad !== 0) $display("FAIL abort_partial: we=%0d bad=%0d want 50 0", we_cnt, addr_bad); else n_pass++;
      n_checks++; if (load_err !== 1'b0) $display("FAIL abort_err_early: got %b want 0", load_err); else n_pass++;
      @(negedge clk); #2;
      n_checks++; if (load_err !== 1'b1 || dut.state_q !== ST_IDLE) $display("FAIL abort_err_pulse: le=%b st=%0d want 1 %0d", load_err, dut.state_q, ST_IDLE); else n_pass++;
      @(negedge clk); #2;
      n_checks++; if (load_err !== 1'b0) $display("FAIL abort_err_width: got %b want 0", load_err); else n_pass++;
      do_load(2'd1, 512); #2;
      n_checks++;
      if (we_cnt !== 512 || addr_bad !== 0 || first_a !== 13'h0000 || last_a !== 13'h1F0F)
         $display("FAIL reload: we=%0d bad=%0d first=%h last=%h want 512 0 0000 1f0f", we_cnt, addr_bad, first_a, last_a);
      else n_pass++;
      n_checks++; if (dut.state_q !== ST_WAIT_CMD || cmd_size !== 2'd1) $display("FAIL reload_state: st=%0d sz=%0d want %0d 1", dut.state_q, cmd_size, ST_WAIT_CMD); else n_pass++;
   endtask

   task automatic test_rst_wait_dp();
      @(negedge clk); in_valid2 = 1; matrix_idx = 5'd4; mode = 2'd3; #2;
      @(negedge clk); matrix_idx = 5'd5; #2;
      @(negedge clk); matrix_idx = 5'd6; #2;
      @(negedge clk); in_valid2 = 0; matrix_idx = 0; mode = 0; #2;
      @(negedge clk); #2;
      @(negedge clk); #2;
      n_checks++; if (dut.state_q !== ST_WAIT_DP) $display("FAIL rstdp_pre_state: got %0d want %0d", dut.state_q, ST_WAIT_DP); else n_pass++;
      @(negedge clk); rst = 1; #2;
      @(negedge clk); rst = 0; dp_done = 1; dp_result = 50'sd123; #2;
      n_checks++; if (dut.state_q !== ST_IDLE) $display("FAIL rstdp_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
      cv_cnt = 0; ov_cnt = 0; zero_bad = 0;
      @(negedge clk); dp_done = 0; dp_result = 0; #2; sample_outs();
      @(negedge clk); #2; sample_outs();
      n_checks++; if (ov_cnt !== 0 || cv_cnt !== 0 || zero_bad !== 0) $display("FAIL rstdp_no_out: ov=%0d cv=%0d zbad=%0d want 0 0 0", ov_cnt, cv_cnt, zero_bad); else n_pass++;
      n_checks++;
      if ({mem_we, load_err} !== 2'b0 || mem_waddr !== 13'd0 || {cmd_idx_a, cmd_idx_b, cmd_idx_c, cmd_mode, cmd_size} !== 19'd0)
         $display("FAIL rstdp_outputs: we=%b le=%b addr=%h a=%0d b=%0d c=%0d m=%0d s=%0d want all 0",
                  mem_we, load_err, mem_waddr, cmd_idx_a, cmd_idx_b, cmd_idx_c, cmd_mode, cmd_size);
      else n_pass++;
   endtask

   task automatic test_load_size3();
      do_load(2'd3, 8192); #2;
      n_checks++;
      if (we_cnt !== 8192 || addr_bad !== 0 || first_a !== 13'h0000 || last_a !== 13'h1FFF)
         $display("FAIL load3: we=%0d bad=%0d first=%h last=%h want 8192 0 0000 1fff", we_cnt, addr_bad, first_a, last_a);
      else n_pass++;
      n_checks++; if (dut.state_q !== ST_WAIT_CMD || cmd_size !== 2'd3) $display("FAIL load3_state: st=%0d sz=%0d want %0d 3", dut.state_q, cmd_size, ST_WAIT_CMD); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_load_size0();
      test_command();
      test_discard();
      test_rounds();
      test_load_err();
      test_rst_wait_dp();
      test_load_size3();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
